register_write_scheduler: RTL and testbench
===========================================

# register_write_scheduler

Sequences the three-slot register write-back buffer between the execute stage and the shared single-write-port integer/float register file. Results are queued in age order, and the oldest entry retires to the register file whenever the port is available. Every slot's enable/addr/float/data is exported so the forwarding mux can pick the newest matching pending value. Slot 2 is the newest position, consistent with the forwarding priority "higher slot wins".

## Interface
Parameters:
- DEPTH, 3, number of buffer slots (fixed at 3; forwarding mux has three slot inputs)
- WIDTH, 32, data width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears the buffer
- in_valid  in  1  execute stage presents a result this cycle
- in_addr  in  5  destination register
- in_float  in  1  1 = float register file, 0 = integer
- in_data  in  WIDTH  result value
- in_ready  out  1  buffer accepts the push this cycle
- rf_ready  in  1  register file write port free this cycle
- rf_we  out  1  retire oldest entry this cycle
- rf_addr  out  5  retiring address
- rf_float  out  1  retiring file select
- rf_data  out  WIDTH  retiring data
- write_enable_0/1/2  out  1  slot k holds a valid pending write
- write_addr_0/1/2  out  5  slot k address
- write_float_0/1/2  out  1  slot k file select
- write_data_0/1/2  out  WIDTH  slot k data
- count  out  2  number of valid slots, 0..3

## Operation
- Buffer is compacting. Valid slots are always 0..count-1. Slot 0 is oldest; slot count-1 is newest.
- Drain:
  - rf_we = write_enable_0 & rf_ready (combinational).
  - rf_addr/rf_float/rf_data = slot 0 fields.
  - On drain, slots 1..2 shift down by one at the clock edge.
- Push:
  - in_ready = (count < 3) | rf_we (combinational).
  - Push accepted iff in_valid & in_ready.
  - Entry lands in slot (count - drain), i.e. directly above the surviving entries.
- Integer register 0 writes (in_float=0, in_addr=0):
  - Accepted (in_ready as normal) but discarded.
  - Never occupy a slot.
  - Float register 0 is a real register and is buffered.
- No coalescing: two pending writes to the same register both occupy slots. Retirement order preserves last-write-wins; forwarding picks the higher slot.
- Next count = count + push_stored - drain, where push_stored excludes discarded $zero pushes. Count never exceeds 3 or underflows.
- Invalid slots drive enable 0. Their addr/float/data are don't-care, but must be held stable rather than X after reset.

## Timing
- Reset (async assert, sync-safe release):
  - count=0, all write_enable_k=0, all slot fields=0.
  - rf_we=0, in_ready=1.
- Push-to-visible latency: 1 cycle. A value pushed at edge N appears on write_* after edge N. It is not forwarded in the push cycle; the execute stage bypasses that itself.
- Push-to-retire: earliest 1 cycle (pushed at edge N into an empty buffer, rf_we high in cycle N+1 if rf_ready).
- Simultaneous push and drain:
  - At count=3, both are allowed, and the new entry lands in slot 2.
  - At count=0, no drain occurs; the push lands in slot 0.
- Full (count=3) and rf_ready=0: in_ready=0. Upstream holds in_valid and the result; nothing changes.
- rf_ready deasserted: the buffer only fills; contents are frozen apart from appends.
- Reset mid-operation: pending writes are lost and no partial rf_we occurs after assertion. The pipeline flush is the owner's responsibility.

## Test plan
- Reset then idle: count=0, all write_enable_k=0, in_ready=1, rf_we=0 for 5 cycles.
- rf_ready=0, push r3=0x11, r4=0x22, f3=0x33:
  - count=3; slots 0/1/2 = (3,int,0x11)/(4,int,0x22)/(3,float,0x33).
  - A 4th push sees in_ready=0 and nothing changes.
- Full buffer, rf_ready=1 with simultaneous push r5=0x55:
  - rf_we=1 retiring r3=0x11.
  - Next cycle slots = r4, f3, r5 and count=3.
- Push integer r0=0xFF then f0=0xEE:
  - Only f0 is stored; count=1 and slot 0 = (0,float,0xEE).
- Two pushes to r7 (0xA then 0xB) with rf_ready=1 continuously:
  - rf_we order is 0xA then 0xB on consecutive cycles; count returns to 0.
- Assert reset asynchronously mid-cycle with count=2:
  - Outputs clear immediately without waiting for a clock edge.
  - After release, first push lands in slot 0.

Source files
------------

// File: rtl/register_write_scheduler.sv
// Three-slot compacting write-back buffer between execute and the shared
// single-port integer/float register file. Slot 0 is the oldest entry and
// retires first; every slot is exported for the forwarding mux.
module register_write_scheduler #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [4:0]       in_addr,
  input  logic             in_float,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             rf_ready,
  output logic             rf_we,
  output logic [4:0]       rf_addr,
  output logic             rf_float,
  output logic [WIDTH-1:0] rf_data,
  output logic             write_enable_0,
  output logic             write_enable_1,
  output logic             write_enable_2,
  output logic [4:0]       write_addr_0,
  output logic [4:0]       write_addr_1,
  output logic [4:0]       write_addr_2,
  output logic             write_float_0,
  output logic             write_float_1,
  output logic             write_float_2,
  output logic [WIDTH-1:0] write_data_0,
  output logic [WIDTH-1:0] write_data_1,
  output logic [WIDTH-1:0] write_data_2,
  output logic [1:0]       count
);

  localparam int unsigned AW    = 5;
  localparam int unsigned SLOTS = 3;

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic             flt;
    logic [WIDTH-1:0] data;
  } slot_t;

  slot_t      slot_q [SLOTS];
  slot_t      slot_d [SLOTS];
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       drain;
  logic       push;
  logic       store;
  logic       is_zero_reg;
  logic [1:0] base;

  // Drain/push handshake; integer r0 pushes are accepted but dropped.
  always_comb begin
    drain       = (count_q != 2'd0) & rf_ready;
    in_ready    = (count_q < 2'(DEPTH)) | drain;
    push        = in_valid & in_ready;
    is_zero_reg = ~in_float & (in_addr == 5'd0);
    store       = push & ~is_zero_reg;
    base        = count_q - 2'(drain);
  end

  // Next slot contents: shift down on drain, then append above survivors.
  always_comb begin
    for (int k = 0; k < SLOTS; k++) begin
      slot_d[k] = slot_q[k];
    end
    if (drain) begin
      slot_d[0] = slot_q[1];
      slot_d[1] = slot_q[2];
    end
    for (int k = 0; k < SLOTS; k++) begin
      if (store && (base == 2'(k))) begin
        slot_d[k].addr = in_addr;
        slot_d[k].flt  = in_float;
        slot_d[k].data = in_data;
      end
    end
    count_d = count_q + 2'(store) - 2'(drain);
  end

  // Slot and occupancy registers; reset clears everything to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 2'd0;
      for (int k = 0; k < SLOTS; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int k = 0; k < SLOTS; k++) begin
        slot_q[k] <= slot_d[k];
      end
    end
  end

  // Export retire port and per-slot forwarding view.
  always_comb begin
    rf_we          = drain;
    rf_addr        = slot_q[0].addr;
    rf_float       = slot_q[0].flt;
    rf_data        = slot_q[0].data;
    write_enable_0 = count_q > 2'd0;
    write_enable_1 = count_q > 2'd1;
    write_enable_2 = count_q > 2'd2;
    write_addr_0   = slot_q[0].addr;
    write_addr_1   = slot_q[1].addr;
    write_addr_2   = slot_q[2].addr;
    write_float_0  = slot_q[0].flt;
    write_float_1  = slot_q[1].flt;
    write_float_2  = slot_q[2].flt;
    write_data_0   = slot_q[0].data;
    write_data_1   = slot_q[1].data;
    write_data_2   = slot_q[2].data;
    count          = count_q;
  end

endmodule

// File: tb/tb_register_write_scheduler.sv
// Directed bench for register_write_scheduler: fill, drain-with-push,
// $zero discard, same-register ordering and asynchronous reset.
module tb_register_write_scheduler;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [4:0]       in_addr;
  logic             in_float;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             rf_ready;
  logic             rf_we;
  logic [4:0]       rf_addr;
  logic             rf_float;
  logic [WIDTH-1:0] rf_data;
  logic             write_enable_0, write_enable_1, write_enable_2;
  logic [4:0]       write_addr_0, write_addr_1, write_addr_2;
  logic             write_float_0, write_float_1, write_float_2;
  logic [WIDTH-1:0] write_data_0, write_data_1, write_data_2;
  logic [1:0]       count;

  int passed = 0;
  int total  = 0;

  register_write_scheduler #(.DEPTH(3), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_addr(in_addr), .in_float(in_float), .in_data(in_data),
    .in_ready(in_ready), .rf_ready(rf_ready),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_float(rf_float), .rf_data(rf_data),
    .write_enable_0(write_enable_0), .write_enable_1(write_enable_1), .write_enable_2(write_enable_2),
    .write_addr_0(write_addr_0), .write_addr_1(write_addr_1), .write_addr_2(write_addr_2),
    .write_float_0(write_float_0), .write_float_1(write_float_1), .write_float_2(write_float_2),
    .write_data_0(write_data_0), .write_data_1(write_data_1), .write_data_2(write_data_2),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Set up one cycle's inputs just after the falling edge.
  task automatic drive(input logic v, input logic [4:0] a, input logic f, input logic [WIDTH-1:0] d);
    @(negedge clk);
    in_valid = v;
    in_addr  = a;
    in_float = f;
    in_data  = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rf_ready = 1'b0;
    in_valid = 1'b0; in_addr = 5'd0; in_float = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (count !== 2'd0) $display("FAIL reset_count cyc%0d got %0d exp 0", i, count); else passed++;
      total++; if ({write_enable_2, write_enable_1, write_enable_0} !== 3'b000)
        $display("FAIL reset_enables cyc%0d got %b exp 000", i, {write_enable_2, write_enable_1, write_enable_0}); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready cyc%0d got %b exp 1", i, in_ready); else passed++;
      total++; if (rf_we !== 1'b0) $display("FAIL reset_rf_we cyc%0d got %b exp 0", i, rf_we); else passed++;
    end
    total++; if (write_data_0 !== 32'h0) $display("FAIL reset_data0 got %h exp 0", write_data_0); else passed++;
  endtask

  task automatic test_fill();
    rf_ready = 1'b0;
    drive(1'b1, 5'd3, 1'b0, 32'h11); tick();
    total++; if (count !== 2'd1) $display("FAIL fill_count1 got %0d exp 1", count); else passed++;
    drive(1'b1, 5'd4, 1'b0, 32'h22); tick();
    drive(1'b1, 5'd3, 1'b1, 32'h33); tick();
    total++; if (count !== 2'd3) $display("FAIL fill_count3 got %0d exp 3", count); else passed++;
    total++; if ({write_enable_2, write_enable_1, write_enable_0} !== 3'b111)
      $display("FAIL fill_enables got %b exp 111", {write_enable_2, write_enable_1, write_enable_0}); else passed++;
    total++; if ({write_addr_0, write_float_0, write_data_0} !== {5'd3, 1'b0, 32'h11})
      $display("FAIL fill_slot0 got %0d/%b/%h exp 3/0/11", write_addr_0, write_float_0, write_data_0); else passed++;
    total++; if ({write_addr_1, write_float_1, write_data_1} !== {5'd4, 1'b0, 32'h22})
      $display("FAIL fill_slot1 got %0d/%b/%h exp 4/0/22", write_addr_1, write_float_1, write_data_1); else passed++;
    total++; if ({write_addr_2, write_float_2, write_data_2} !== {5'd3, 1'b1, 32'h33})
      $display("FAIL fill_slot2 got %0d/%b/%h exp 3/1/33", write_addr_2, write_float_2, write_data_2); else passed++;
    // Fourth push against a full, stalled buffer.
    drive(1'b1, 5'd9, 1'b0, 32'h99);
    total++; if (in_ready !== 1'b0) $display("FAIL full_in_ready got %b exp 0", in_ready); else passed++;
    total++; if (rf_we !== 1'b0) $display("FAIL full_rf_we got %b exp 0", rf_we); else passed++;
    tick();
    total++; if (count !== 2'd3) $display("FAIL full_count got %0d exp 3", count); else passed++;
    total++; if ({write_addr_2, write_float_2, write_data_2} !== {5'd3, 1'b1, 32'h33})
      $display("FAIL full_slot2 got %0d/%b/%h exp 3/1/33", write_addr_2, write_float_2, write_data_2); else passed++;
  endtask

  task automatic test_drain_push();
    drive(1'b1, 5'd5, 1'b0, 32'h55);
    rf_ready = 1'b1;
    #1;
    total++; if (rf_we !== 1'b1) $display("FAIL dp_rf_we got %b exp 1", rf_we); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL dp_in_ready got %b exp 1", in_ready); else passed++;
    total++; if ({rf_addr, rf_float, rf_data} !== {5'd3, 1'b0, 32'h11})
      $display("FAIL dp_retire got %0d/%b/%h exp 3/0/11", rf_addr, rf_float, rf_data); else passed++;
    tick();
    total++; if (count !== 2'd3) $display("FAIL dp_count got %0d exp 3", count); else passed++;
    total++; if ({write_addr_0, write_float_0, write_data_0} !== {5'd4, 1'b0, 32'h22})
      $display("FAIL dp_slot0 got %0d/%b/%h exp 4/0/22", write_addr_0, write_float_0, write_data_0); else passed++;
    total++; if ({write_addr_1, write_float_1, write_data_1} !== {5'd3, 1'b1, 32'h33})
      $display("FAIL dp_slot1 got %0d/%b/%h exp 3/1/33", write_addr_1, write_float_1, write_data_1); else passed++;
    total++; if ({write_addr_2, write_float_2, write_data_2} !== {5'd5, 1'b0, 32'h55})
      $display("FAIL dp_slot2 got %0d/%b/%h exp 5/0/55", write_addr_2, write_float_2, write_data_2); else passed++;
    // Empty the buffer: three plain drains.
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    repeat (3) tick();
    total++; if (count !== 2'd0) $display("FAIL dp_empty_count got %0d exp 0", count); else passed++;
    total++; if (rf_we !== 1'b0) $display("FAIL dp_empty_rf_we got %b exp 0", rf_we); else passed++;
  endtask

  task automatic test_zero_reg();
    rf_ready = 1'b0;
    drive(1'b1, 5'd0, 1'b0, 32'hFF);
    total++; if (in_ready !== 1'b1) $display("FAIL zero_in_ready got %b exp 1", in_ready); else passed++;
    tick();
    total++; if (count !== 2'd0) $display("FAIL zero_int_count got %0d exp 0", count); else passed++;
    drive(1'b1, 5'd0, 1'b1, 32'hEE); tick();
    total++; if (count !== 2'd1) $display("FAIL zero_flt_count got %0d exp 1", count); else passed++;
    total++; if ({write_enable_1, write_enable_0} !== 2'b01)
      $display("FAIL zero_enables got %b exp 01", {write_enable_1, write_enable_0}); else passed++;
    total++; if ({write_addr_0, write_float_0, write_data_0} !== {5'd0, 1'b1, 32'hEE})
      $display("FAIL zero_slot0 got %0d/%b/%h exp 0/1/ee", write_addr_0, write_float_0, write_data_0); else passed++;
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    rf_ready = 1'b1;
    tick();
    total++; if (count !== 2'd0) $display("FAIL zero_drain_count got %0d exp 0", count); else passed++;
  endtask

  task automatic test_back_to_back();
    rf_ready = 1'b1;
    drive(1'b1, 5'd7, 1'b0, 32'hA);
    total++; if (rf_we !== 1'b0) $display("FAIL b2b_empty_rf_we got %b exp 0", rf_we); else passed++;
    tick();
    drive(1'b1, 5'd7, 1'b0, 32'hB);
    total++; if ({rf_we, rf_addr, rf_data} !== {1'b1, 5'd7, 32'hA})
      $display("FAIL b2b_first got we%b %0d/%h exp we1 7/a", rf_we, rf_addr, rf_data); else passed++;
    tick();
    total++; if (count !== 2'd1) $display("FAIL b2b_mid_count got %0d exp 1", count); else passed++;
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    total++; if ({rf_we, rf_addr, rf_data} !== {1'b1, 5'd7, 32'hB})
      $display("FAIL b2b_second got we%b %0d/%h exp we1 7/b", rf_we, rf_addr, rf_data); else passed++;
    tick();
    total++; if (count !== 2'd0) $display("FAIL b2b_end_count got %0d exp 0", count); else passed++;
  endtask

  task automatic test_async_reset();
    rf_ready = 1'b0;
    drive(1'b1, 5'd1, 1'b0, 32'h101); tick();
    drive(1'b1, 5'd2, 1'b0, 32'h202); tick();
    total++; if (count !== 2'd2) $display("FAIL ar_pre_count got %0d exp 2", count); else passed++;
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    rf_ready = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    total++; if (count !== 2'd0) $display("FAIL ar_count got %0d exp 0", count); else passed++;
    total++; if ({write_enable_1, write_enable_0} !== 2'b00)
      $display("FAIL ar_enables got %b exp 00", {write_enable_1, write_enable_0}); else passed++;
    total++; if (rf_we !== 1'b0) $display("FAIL ar_rf_we got %b exp 0", rf_we); else passed++;
    total++; if ({write_addr_0, write_data_0} !== {5'd0, 32'h0})
      $display("FAIL ar_slot0 got %0d/%h exp 0/0", write_addr_0, write_data_0); else passed++;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    rf_ready = 1'b0;
    drive(1'b1, 5'd9, 1'b0, 32'h99); tick();
    total++; if (count !== 2'd1) $display("FAIL ar_post_count got %0d exp 1", count); else passed++;
    total++; if ({write_addr_0, write_float_0, write_data_0} !== {5'd9, 1'b0, 32'h99})
      $display("FAIL ar_post_slot0 got %0d/%b/%h exp 9/0/99", write_addr_0, write_float_0, write_data_0); else passed++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain_push();
    test_zero_reg();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
